// File: rtl/puf_uart_pkg.sv
// Shared definitions for the PUF challenge/response requester:
// FSM state encoding, error codes and default response word size.
package puf_uart_pkg;

  localparam int unsigned RESP_BYTES = 32;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ECHO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_RX_ECHO,
    ST_RX_RESP,
    ST_RX_ECHO2,
    ST_RX_RESP2,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_e;

  // States in which a byte is expected and the idle timer runs.
  function automatic logic is_rx_state(state_e s);
    return (s == ST_RX_ECHO) || (s == ST_RX_RESP) || (s == ST_RX_ECHO2) ||
           (s == ST_RX_RESP2) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/puf_idle_timer.sv
// Idle-cycle counter between received bytes; expired_o rises once the
// count reaches LIMIT-1 and the counter then holds until cleared.
module puf_idle_timer #(
  parameter int unsigned TO_W  = 20,
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;

  assign expired_o = (cnt_q == TO_W'(LIMIT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/puf_crp_requester.sv
// Host-side requester: sends one challenge byte over UART and reassembles
// the echoed reply into one or two response words, or reports an error.
module puf_crp_requester #(
  parameter int unsigned RESP_BYTES     = puf_uart_pkg::RESP_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [7:0]              req_challenge,
  input  logic                    req_second,
  output logic                    req_ready,
  output logic                    busy,
  output logic [7:0]              tx_byte,
  output logic                    tx_DV,
  input  logic                    tx_done,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_DV,
  output logic [8*RESP_BYTES-1:0] resp_data,
  output logic [8*RESP_BYTES-1:0] resp_second,
  output logic                    resp_valid,
  output logic                    resp_error,
  output logic [1:0]              err_code
);

  import puf_uart_pkg::*;

  localparam int unsigned W    = 8 * RESP_BYTES;
  localparam int unsigned BC_W = $clog2(RESP_BYTES + 1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(RESP_BYTES - 1);

  state_e          state_q;
  logic [7:0]      chal_q;
  logic            second_q;
  logic [BC_W-1:0] bcnt_q;
  logic [7:0]      tx_byte_q;
  logic            tx_dv_q;
  logic [W-1:0]    resp_data_q;
  logic [W-1:0]    resp_second_q;
  logic            resp_valid_q;
  logic            resp_error_q;
  logic [1:0]      err_code_q;

  logic timer_en;
  logic timer_clear;
  logic expired;

  // Timer only runs while a byte is awaited; every byte restarts it.
  always_comb begin
    timer_en    = is_rx_state(state_q);
    timer_clear = rx_DV || !timer_en;
  end

  puf_idle_timer #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (expired)
  );

  // Strobes are set on the transition into the state they belong to, so
  // tx_DV is high during SEND and the result pulses during DONE/ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      chal_q        <= '0;
      second_q      <= 1'b0;
      bcnt_q        <= '0;
      tx_byte_q     <= '0;
      tx_dv_q       <= 1'b0;
      resp_data_q   <= '0;
      resp_second_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      tx_dv_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            chal_q        <= req_challenge;
            second_q      <= req_second;
            resp_data_q   <= '0;
            resp_second_q <= '0;
            err_code_q    <= ERR_NONE;
            tx_byte_q     <= req_challenge;
            tx_dv_q       <= 1'b1;
            state_q       <= ST_SEND;
          end
        end
        ST_SEND: state_q <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (tx_done) state_q <= ST_RX_ECHO;
        end
        ST_RX_ECHO, ST_RX_ECHO2: begin
          if (rx_DV) begin
            if (rx_byte == chal_q) begin
              bcnt_q  <= '0;
              state_q <= (state_q == ST_RX_ECHO) ? ST_RX_RESP : ST_RX_RESP2;
            end else begin
              err_code_q <= ERR_ECHO;
              state_q    <= ST_DRAIN;
            end
          end else if (expired) begin
            err_code_q   <= ERR_TIMEOUT;
            resp_error_q <= 1'b1;
            state_q      <= ST_ERR;
          end
        end
        ST_RX_RESP, ST_RX_RESP2: begin
          if (rx_DV) begin
            if (state_q == ST_RX_RESP) resp_data_q <= {resp_data_q[W-9:0], rx_byte};
            else                       resp_second_q <= {resp_second_q[W-9:0], rx_byte};
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == LAST_BYTE) begin
              if (state_q == ST_RX_RESP && second_q) begin
                state_q <= ST_RX_ECHO2;
              end else begin
                resp_valid_q <= 1'b1;
                state_q      <= ST_DONE;
              end
            end
          end else if (expired) begin
            err_code_q   <= ERR_TIMEOUT;
            resp_error_q <= 1'b1;
            state_q      <= ST_ERR;
          end
        end
        ST_DRAIN: begin
          if (!rx_DV && expired) begin
            resp_error_q <= 1'b1;
            state_q      <= ST_ERR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = ~req_ready;
  assign tx_byte     = tx_byte_q;
  assign tx_DV       = tx_dv_q;
  assign resp_data   = resp_data_q;
  assign resp_second = resp_second_q;
  assign resp_valid  = resp_valid_q;
  assign resp_error  = resp_error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_puf_crp_requester.sv
// Self-checking bench for puf_crp_requester with a short timeout and a
// UART TX model that answers tx_DV with tx_done ten cycles later.
module tb_puf_crp_requester;

  localparam int unsigned T  = 100;
  localparam int unsigned RB = 32;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [3:0]  nvalid;
    logic [3:0]  nerror;
    logic [1:0]  code;
    logic [15:0] lat;
    logic [3:0]  ntx;
    logic [7:0]  txb;
    logic [3:0]  nboth;
    logic        ready_after;
  } stat_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic [7:0]     req_challenge = '0;
  logic           req_second = 1'b0;
  logic           req_ready, busy;
  logic [7:0]     tx_byte;
  logic           tx_DV;
  logic           tx_done = 1'b0;
  logic [7:0]     rx_byte = '0;
  logic           rx_DV = 1'b0;
  logic [8*RB-1:0] resp_data, resp_second;
  logic           resp_valid, resp_error;
  logic [1:0]     err_code;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int tx_cnt = 0, valid_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_cyc = 0;
  logic [8*RB-1:0] cap_d1 = '0, cap_d2 = '0;
  logic [1:0] cap_code = '0;
  logic [7:0] cap_txb = '0;

  always #5 clk = ~clk;

  puf_crp_requester #(
    .RESP_BYTES     (RB),
    .TIMEOUT_CYCLES (T),
    .TO_W           (20)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_challenge (req_challenge),
    .req_second    (req_second),
    .req_ready     (req_ready),
    .busy          (busy),
    .tx_byte       (tx_byte),
    .tx_DV         (tx_DV),
    .tx_done       (tx_done),
    .rx_byte       (rx_byte),
    .rx_DV         (rx_DV),
    .resp_data     (resp_data),
    .resp_second   (resp_second),
    .resp_valid    (resp_valid),
    .resp_error    (resp_error),
    .err_code      (err_code)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_DV === 1'b1) begin tx_cnt++; cap_txb = tx_byte; end
    if (resp_valid === 1'b1) begin
      valid_cnt++; pulse_cyc = cyc; cap_d1 = resp_data; cap_d2 = resp_second; cap_code = err_code;
    end
    if (resp_error === 1'b1) begin err_cnt++; pulse_cyc = cyc; cap_code = err_code; end
    if (resp_valid === 1'b1 && resp_error === 1'b1) both_cnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_DV === 1'b1) begin
        repeat (10) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Reference: parse the byte stream against the framing rules.
  function automatic stat_t model(input logic [7:0] chal, input bit second, input bq_t s,
                                  output logic [8*RB-1:0] d1, output logic [8*RB-1:0] d2);
    stat_t e;
    logic [8*RB-1:0] word;
    int p = 0;
    e = '0; e.ntx = 4'd1; e.txb = chal; e.ready_after = 1'b1;
    d1 = '0; d2 = '0;
    for (int w = 0; w < (second ? 2 : 1); w++) begin
      if (p >= s.size()) begin e.nerror = 1; e.code = 2'b10; e.lat = 16'(T); d1 = '0; d2 = '0; return e; end
      if (s[p] != chal) begin e.nerror = 1; e.code = 2'b01; e.lat = 16'(T); d1 = '0; d2 = '0; return e; end
      p++;
      word = '0;
      for (int i = 0; i < RB; i++) begin
        if (p >= s.size()) begin e.nerror = 1; e.code = 2'b10; e.lat = 16'(T); d1 = '0; d2 = '0; return e; end
        word[8*RB-1-8*i -: 8] = s[p];
        p++;
      end
      if (w == 0) d1 = word; else d2 = word;
    end
    e.nvalid = 1; e.lat = 16'd0;
    return e;
  endfunction

  function automatic bq_t rand_stream(input logic [7:0] chal, input bit second);
    bq_t q;
    q.push_back(chal);
    for (int i = 0; i < RB; i++) q.push_back(8'($urandom));
    if (second) begin
      q.push_back(chal);
      for (int i = 0; i < RB; i++) q.push_back(8'($urandom));
    end
    return q;
  endfunction

  task automatic wait_ready();
    for (int n = 0; n < 300 && req_ready !== 1'b1; n++) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL wait_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic do_request(input logic [7:0] chal, input bit second);
    wait_ready();
    req_challenge = chal; req_second = second; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic send_bytes(input bq_t s, output int last);
    last = cyc;
    foreach (s[i]) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rx_byte = s[i]; rx_DV = 1'b1;
      @(negedge clk);
      rx_DV = 1'b0;
      last = cyc;
    end
  endtask

  task automatic run_frame(input logic [7:0] chal, input bit second, input bq_t s,
                           output stat_t st, output logic [8*RB-1:0] d1, output logic [8*RB-1:0] d2);
    int tx0, v0, e0, b0, last;
    bit seen;
    tx0 = tx_cnt; v0 = valid_cnt; e0 = err_cnt; b0 = both_cnt;
    do_request(chal, second);
    send_bytes(s, last);
    seen = 0;
    for (int n = 0; n < 2*T; n++) begin
      if (resp_valid === 1'b1 || resp_error === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    st = '0;
    st.ready_after = req_ready;
    repeat (2) @(negedge clk);
    st.nvalid = 4'(valid_cnt - v0);
    st.nerror = 4'(err_cnt - e0);
    st.nboth  = 4'(both_cnt - b0);
    st.ntx    = 4'(tx_cnt - tx0);
    st.txb    = cap_txb;
    st.code   = seen ? cap_code : 2'b11;
    st.lat    = seen ? 16'(pulse_cyc - last) : 16'hFFFF;
    d1 = (valid_cnt != v0) ? cap_d1 : '0;
    d2 = (valid_cnt != v0) ? cap_d2 : '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_byte, tx_DV, resp_valid, resp_error, err_code} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %h required 0", {tx_byte, tx_DV, resp_valid, resp_error, err_code});
    end
    checks++;
    if ({resp_data, resp_second} !== '0) begin
      errors++; $display("FAIL reset_words: got %h required 0", {resp_data, resp_second});
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready: ready=%b busy=%b required 1/0", req_ready, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    s.push_back(8'hA5);
    for (int i = 0; i < RB; i++) s.push_back(8'(i));
    e = model(8'hA5, 0, s, x1, x2);
    run_frame(8'hA5, 0, s, st, d1, d2);
    checks++;
    if (st !== e) begin errors++; $display("FAIL single status: got %h required %h", st, e); end
    checks++;
    if ({d1, d2} !== {x1, x2}) begin errors++; $display("FAIL single data: got %h_%h required %h_%h", d1, d2, x1, x2); end
  endtask

  task automatic test_double();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    s.push_back(8'hA5);
    for (int i = 0; i < RB; i++) s.push_back(8'(i));
    s.push_back(8'hA5);
    for (int i = 0; i < RB; i++) s.push_back(8'(255 - i));
    e = model(8'hA5, 1, s, x1, x2);
    run_frame(8'hA5, 1, s, st, d1, d2);
    checks++;
    if (st !== e) begin errors++; $display("FAIL double status: got %h required %h", st, e); end
    checks++;
    if ({d1, d2} !== {x1, x2}) begin errors++; $display("FAIL double data: got %h_%h required %h_%h", d1, d2, x1, x2); end
  endtask

  task automatic test_echo_mismatch();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    s.push_back(8'h3D);
    for (int i = 0; i < RB; i++) s.push_back(8'($urandom));
    e = model(8'h3C, 0, s, x1, x2);
    run_frame(8'h3C, 0, s, st, d1, d2);
    checks++;
    if (st !== e) begin errors++; $display("FAIL echo status: got %h required %h", st, e); end
    s = rand_stream(8'h3C, 0);
    e = model(8'h3C, 0, s, x1, x2);
    run_frame(8'h3C, 0, s, st, d1, d2);
    checks++;
    if (st !== e) begin errors++; $display("FAIL echo_recover status: got %h required %h", st, e); end
    checks++;
    if ({d1, d2} !== {x1, x2}) begin errors++; $display("FAIL echo_recover data: got %h_%h required %h_%h", d1, d2, x1, x2); end
  endtask

  task automatic test_timeout();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    s.push_back(8'h5A);
    for (int i = 0; i < 5; i++) s.push_back(8'($urandom));
    e = model(8'h5A, 0, s, x1, x2);
    run_frame(8'h5A, 0, s, st, d1, d2);
    checks++;
    if (st !== e) begin errors++; $display("FAIL timeout status: got %h required %h", st, e); end
    repeat (5) @(negedge clk);
    checks++;
    if (err_code !== 2'b10) begin errors++; $display("FAIL timeout_hold: err_code=%b required 10", err_code); end
  endtask

  task automatic test_reset_mid();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    int v0, e0, last;
    v0 = valid_cnt; e0 = err_cnt;
    s.push_back(8'hC3);
    for (int i = 0; i < 16; i++) s.push_back(8'($urandom_range(1, 255)));
    do_request(8'hC3, 1);
    send_bytes(s, last);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_byte, tx_DV, resp_valid, resp_error, err_code, resp_data, resp_second} !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got %h required 0", {tx_byte, tx_DV, resp_valid, resp_error, err_code, resp_data, resp_second});
    end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid ready: got %b required 1", req_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      errors++; $display("FAIL reset_mid pulses: got %0d/%0d required 0/0", valid_cnt - v0, err_cnt - e0);
    end
    s = rand_stream(8'hC3, 1);
    e = model(8'hC3, 1, s, x1, x2);
    run_frame(8'hC3, 1, s, st, d1, d2);
    checks++;
    if (st !== e || {d1, d2} !== {x1, x2}) begin
      errors++; $display("FAIL reset_mid frame: got %h %h_%h required %h %h_%h", st, d1, d2, e, x1, x2);
    end
  endtask

  task automatic test_back_to_back();
    bq_t s1, s2; stat_t e; logic [8*RB-1:0] x1, x2;
    int tx0, v0, last;
    tx0 = tx_cnt; v0 = valid_cnt;
    s1 = rand_stream(8'h77, 0);
    s2 = rand_stream(8'h77, 0);
    wait_ready();
    req_challenge = 8'h77; req_second = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    repeat (12) @(negedge clk);
    send_bytes(s1, last);
    checks++;
    if (tx_cnt - tx0 != 1 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b first: sends=%0d valid=%b required 1/1", tx_cnt - tx0, resp_valid);
    end
    repeat (14) @(negedge clk);
    req_valid = 1'b0;
    send_bytes(s2, last);
    for (int n = 0; n < 2*T && resp_valid !== 1'b1; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    e = model(8'h77, 0, s2, x1, x2);
    checks++;
    if (tx_cnt - tx0 != 2 || valid_cnt - v0 != 2) begin
      errors++; $display("FAIL b2b counts: sends=%0d valids=%0d required 2/2", tx_cnt - tx0, valid_cnt - v0);
    end
    checks++;
    if (cap_d1 !== x1 || cap_d2 !== x2) begin
      errors++; $display("FAIL b2b data: got %h_%h required %h_%h", cap_d1, cap_d2, x1, x2);
    end
  endtask

  task automatic test_random();
    bq_t s; stat_t st, e; logic [8*RB-1:0] d1, d2, x1, x2;
    logic [7:0] c; bit sec; int kind, idx, len;
    for (int k = 0; k < 8; k++) begin
      c = 8'($urandom); sec = 1'($urandom_range(0, 1)); kind = $urandom_range(0, 3);
      s = rand_stream(c, sec);
      if (kind == 2) begin
        idx = (sec && $urandom_range(0, 1) == 1) ? RB + 1 : 0;
        s[idx] = s[idx] ^ 8'($urandom_range(1, 255));
      end else if (kind == 3) begin
        len = $urandom_range(1, s.size() - 1);
        while (s.size() > len) void'(s.pop_back());
      end
      e = model(c, sec, s, x1, x2);
      run_frame(c, sec, s, st, d1, d2);
      checks++;
      if (st !== e || {d1, d2} !== {x1, x2}) begin
        errors++; $display("FAIL random[%0d] kind %0d: got %h %h_%h required %h %h_%h", k, kind, st, d1, d2, e, x1, x2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_echo_mismatch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
